// File: rtl/apb_mst_if.sv
// APB4/5 requester bridge: turns a valid/ready command into one APB transfer
// and returns a held response. Misaligned commands complete with an error and no bus access.
module apb_mst_if #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256,
  localparam int STRB_WIDTH    = DATA_WIDTH / 8
) (
  input  logic                  pclk_i,
  input  logic                  prst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic                  req_we_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  input  logic [STRB_WIDTH-1:0] req_strb_i,
  input  logic [2:0]            req_prot_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic [ADDR_WIDTH-1:0] paddr_o,
  output logic [3:0]            pprot_o,
  output logic                  pnse_o,
  output logic                  psel_o,
  output logic                  penable_o,
  output logic                  pwrite_o,
  output logic [DATA_WIDTH-1:0] pwdata_o,
  output logic [STRB_WIDTH-1:0] pstrb_o,
  input  logic                  pready_i,
  input  logic [DATA_WIDTH-1:0] prdata_i,
  input  logic                  pslverr_i,
  output logic                  pwakeup_o
);

  // Counter holds TIMEOUT_CYCLES itself without wrapping.
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t                state_q, state_d;
  logic                  req_ready_q, req_ready_d;
  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  pwakeup_q, pwakeup_d;
  logic                  pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic [STRB_WIDTH-1:0] pstrb_q, pstrb_d;
  logic [3:0]            pprot_q, pprot_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  always_ff @(posedge pclk_i or negedge prst_ni) begin
    if (!prst_ni) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b1;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwakeup_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      pprot_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwakeup_q   <= pwakeup_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pstrb_q     <= pstrb_d;
      pprot_q     <= pprot_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    req_ready_d = req_ready_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwakeup_d   = pwakeup_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    pstrb_d     = pstrb_q;
    pprot_d     = pprot_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    cnt_d       = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid_i && req_ready_q) begin
          req_ready_d = 1'b0;
          if (req_addr_i[1:0] == 2'b00) begin
            state_d   = SETUP;
            psel_d    = 1'b1;
            penable_d = 1'b0;
            pwakeup_d = 1'b1;
            paddr_d   = req_addr_i;
            pwrite_d  = req_we_i;
            pwdata_d  = req_we_i ? req_wdata_i : '0;
            pstrb_d   = req_we_i ? req_strb_i : '0;
            pprot_d   = {1'b0, req_prot_i};
            cnt_d     = '0;
          end else begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
      end
      ACCESS: begin
        // A ready completer on the last allowed cycle still completes normally.
        if (pready_i) begin
          state_d     = RESP;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          pwakeup_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = pslverr_i;
          rsp_rdata_d = pwrite_q ? '0 : prdata_i;
        end else if (TO_EN && (cnt_q == CNT_LAST)) begin
          state_d     = RESP;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          pwakeup_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
        end else if (TO_EN) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_ready_o = req_ready_q;
  assign psel_o      = psel_q;
  assign penable_o   = penable_q;
  assign pwakeup_o   = pwakeup_q;
  assign pwrite_o    = pwrite_q;
  assign paddr_o     = paddr_q;
  assign pwdata_o    = pwdata_q;
  assign pstrb_o     = pstrb_q;
  assign pprot_o     = pprot_q;
  assign pnse_o      = 1'b0;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_err_o   = rsp_err_q;
  assign rsp_rdata_o = rsp_rdata_q;

endmodule

// File: tb/tb_apb_mst_if.sv
// Bench for apb_mst_if: scenario tasks with a response scoreboard queue.
module tb_apb_mst_if;

  logic        pclk = 1'b0;
  logic        prst_ni = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [3:0]  req_strb = '0;
  logic [2:0]  req_prot = '0;
  logic        pready = 1'b0, pslverr = 1'b0;
  logic [31:0] prdata = '0;

  logic        req_ready_o, rsp_valid_o, rsp_err_o, pnse_o, psel_o, penable_o, pwrite_o, pwakeup_o;
  logic [31:0] rsp_rdata_o, paddr_o, pwdata_o;
  logic [3:0]  pprot_o, pstrb_o;

  typedef struct packed { logic [31:0] rdata; logic err; } exp_t;
  exp_t sb[$];
  int n_chk = 0;
  int n_fail = 0;

  apb_mst_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
    .pclk_i(pclk), .prst_ni(prst_ni),
    .req_valid_i(req_valid), .req_ready_o(req_ready_o), .req_addr_i(req_addr),
    .req_we_i(req_we), .req_wdata_i(req_wdata), .req_strb_i(req_strb), .req_prot_i(req_prot),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
    .paddr_o(paddr_o), .pprot_o(pprot_o), .pnse_o(pnse_o), .psel_o(psel_o), .penable_o(penable_o),
    .pwrite_o(pwrite_o), .pwdata_o(pwdata_o), .pstrb_o(pstrb_o), .pready_i(pready),
    .prdata_i(prdata), .pslverr_i(pslverr), .pwakeup_o(pwakeup_o)
  );

  always #5 pclk = ~pclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic exp_t mk(input logic [31:0] rd, input logic err);
    exp_t e;
    e.rdata = rd;
    e.err   = err;
    return e;
  endfunction

  // Called at a negedge; returns at the negedge after the handshake edge.
  task automatic issue(input logic [31:0] a, input logic we, input logic [31:0] wd,
                       input logic [3:0] st, input logic [2:0] pr);
    int t = 0;
    while (!req_ready_o && t < 50) begin @(negedge pclk); t++; end
    req_addr = a; req_we = we; req_wdata = wd; req_strb = st; req_prot = pr;
    req_valid = 1'b1;
    @(negedge pclk);
    req_valid = 1'b0;
  endtask

  task automatic ack_rsp();
    rsp_ready = 1'b1;
    @(negedge pclk);
    rsp_ready = 1'b0;
  endtask

  task automatic pop_exp(output exp_t e, output bit ok);
    ok = (sb.size() != 0);
    e  = ok ? sb.pop_front() : mk('0, 1'b0);
  endtask

  task automatic test_reset();
    prst_ni = 1'b0;
    repeat (3) @(negedge pclk);
    n_chk++;
    if (psel_o !== 0 || penable_o !== 0 || rsp_valid_o !== 0 || pwakeup_o !== 0 || pnse_o !== 0 || paddr_o !== 0) begin
      n_fail++;
      $display("FAIL reset_outputs: psel=%b pen=%b rv=%b wk=%b nse=%b paddr=%h, expected all 0",
               psel_o, penable_o, rsp_valid_o, pwakeup_o, pnse_o, paddr_o);
    end
    prst_ni = 1'b1;
    @(negedge pclk);
    n_chk++;
    if (req_ready_o !== 1 || rsp_valid_o !== 0 || psel_o !== 0) begin
      n_fail++;
      $display("FAIL reset_release: req_ready=%b rsp_valid=%b psel=%b, expected 1 0 0", req_ready_o, rsp_valid_o, psel_o);
    end
  endtask

  task automatic test_read();
    exp_t e; bit ok;
    pready = 1'b1; prdata = 32'hA5A5_0001; pslverr = 1'b0;
    sb.push_back(mk(32'hA5A5_0001, 1'b0));
    issue(32'h0000_0010, 1'b0, 32'hFFFF_FFFF, 4'hF, 3'b101);
    n_chk++;
    if (psel_o !== 1 || penable_o !== 0) begin
      n_fail++; $display("FAIL read_setup: psel=%b penable=%b, expected 1 0", psel_o, penable_o);
    end
    n_chk++;
    if (paddr_o !== 32'h10 || pwrite_o !== 0 || pprot_o !== 4'b0101) begin
      n_fail++; $display("FAIL read_addr: paddr=%h pwrite=%b pprot=%h, expected 10 0 5", paddr_o, pwrite_o, pprot_o);
    end
    n_chk++;
    if (pstrb_o !== 4'h0 || pwdata_o !== 32'h0) begin
      n_fail++; $display("FAIL read_wdata: pstrb=%h pwdata=%h, expected 0 0", pstrb_o, pwdata_o);
    end
    n_chk++;
    if (pwakeup_o !== 1 || req_ready_o !== 0) begin
      n_fail++; $display("FAIL read_wakeup: pwakeup=%b req_ready=%b, expected 1 0", pwakeup_o, req_ready_o);
    end
    @(negedge pclk);
    n_chk++;
    if (psel_o !== 1 || penable_o !== 1) begin
      n_fail++; $display("FAIL read_access: psel=%b penable=%b, expected 1 1", psel_o, penable_o);
    end
    @(negedge pclk);
    n_chk++;
    if (psel_o !== 0 || penable_o !== 0 || rsp_valid_o !== 1 || pwakeup_o !== 0) begin
      n_fail++; $display("FAIL read_done: psel=%b pen=%b rv=%b wk=%b, expected 0 0 1 0", psel_o, penable_o, rsp_valid_o, pwakeup_o);
    end
    pop_exp(e, ok);
    n_chk++;
    if (!ok || rsp_rdata_o !== e.rdata || rsp_err_o !== e.err) begin
      n_fail++; $display("FAIL read_rsp: rdata=%h err=%b, expected %h %b", rsp_rdata_o, rsp_err_o, e.rdata, e.err);
    end
    ack_rsp();
    n_chk++;
    if (rsp_valid_o !== 0 || req_ready_o !== 1) begin
      n_fail++; $display("FAIL read_ack: rsp_valid=%b req_ready=%b, expected 0 1", rsp_valid_o, req_ready_o);
    end
  endtask

  task automatic test_write_wait();
    exp_t e; bit ok; bit stable; int psel_cnt, acc;
    pready = 1'b0; prdata = 32'hCAFE_F00D; pslverr = 1'b0;
    sb.push_back(mk(32'h0, 1'b0));
    issue(32'h0000_0014, 1'b1, 32'h0000_1234, 4'h3, 3'b010);
    stable = 1'b1; psel_cnt = 0; acc = 0;
    for (int c = 0; c < 20 && !rsp_valid_o; c++) begin
      if (psel_o) begin
        psel_cnt++;
        if (paddr_o !== 32'h14 || pwdata_o !== 32'h1234 || pstrb_o !== 4'h3 || pwrite_o !== 1 ||
            pprot_o !== 4'h2 || pwakeup_o !== 1) stable = 1'b0;
      end
      if (psel_o && penable_o) begin acc++; pready = (acc == 3); end
      @(negedge pclk);
    end
    pready = 1'b0;
    n_chk++;
    if (psel_cnt !== 4) begin n_fail++; $display("FAIL write_psel_cycles: got %0d, expected 4", psel_cnt); end
    n_chk++;
    if (stable !== 1'b1) begin n_fail++; $display("FAIL write_stable: bus changed during transfer, got %b expected 1", stable); end
    pop_exp(e, ok);
    n_chk++;
    if (!ok || rsp_valid_o !== 1 || rsp_rdata_o !== e.rdata || rsp_err_o !== e.err) begin
      n_fail++; $display("FAIL write_rsp: rv=%b rdata=%h err=%b, expected 1 %h %b", rsp_valid_o, rsp_rdata_o, rsp_err_o, e.rdata, e.err);
    end
    ack_rsp();
  endtask

  task automatic test_slverr_hold();
    exp_t e; bit ok; bit held;
    pready = 1'b1; prdata = 32'hDEAD_BEEF; pslverr = 1'b1;
    sb.push_back(mk(32'hDEAD_BEEF, 1'b1));
    issue(32'h0000_0020, 1'b0, 32'h0, 4'h0, 3'b000);
    repeat (2) @(negedge pclk);
    pslverr = 1'b0; prdata = 32'h0;
    pop_exp(e, ok);
    n_chk++;
    if (!ok || rsp_valid_o !== 1 || rsp_rdata_o !== e.rdata || rsp_err_o !== e.err) begin
      n_fail++; $display("FAIL slverr_rsp: rv=%b rdata=%h err=%b, expected 1 %h %b", rsp_valid_o, rsp_rdata_o, rsp_err_o, e.rdata, e.err);
    end
    held = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge pclk);
      if (rsp_valid_o !== 1 || rsp_rdata_o !== e.rdata || rsp_err_o !== e.err || req_ready_o !== 0 || psel_o !== 0) held = 1'b0;
    end
    n_chk++;
    if (held !== 1'b1) begin n_fail++; $display("FAIL slverr_hold: response not held under backpressure, got %b expected 1", held); end
    ack_rsp();
    n_chk++;
    if (rsp_valid_o !== 0 || req_ready_o !== 1) begin
      n_fail++; $display("FAIL slverr_ack: rsp_valid=%b req_ready=%b, expected 0 1", rsp_valid_o, req_ready_o);
    end
  endtask

  task automatic test_timeout();
    exp_t e; bit ok; int acc;
    // Completer never ready: aborts after four ACCESS cycles.
    pready = 1'b0; prdata = 32'h5555_AAAA; pslverr = 1'b0;
    sb.push_back(mk(32'h0, 1'b1));
    issue(32'h0000_0030, 1'b0, 32'h0, 4'h0, 3'b000);
    acc = 0;
    for (int c = 0; c < 20 && !rsp_valid_o; c++) begin
      if (psel_o && penable_o) acc++;
      @(negedge pclk);
    end
    n_chk++;
    if (acc !== 4) begin n_fail++; $display("FAIL timeout_cycles: got %0d ACCESS cycles, expected 4", acc); end
    pop_exp(e, ok);
    n_chk++;
    if (!ok || psel_o !== 0 || rsp_rdata_o !== e.rdata || rsp_err_o !== e.err) begin
      n_fail++; $display("FAIL timeout_rsp: psel=%b rdata=%h err=%b, expected 0 %h %b", psel_o, rsp_rdata_o, rsp_err_o, e.rdata, e.err);
    end
    ack_rsp();
    // Ready on the fourth ACCESS cycle completes normally.
    sb.push_back(mk(32'h5555_AAAA, 1'b0));
    issue(32'h0000_0034, 1'b0, 32'h0, 4'h0, 3'b000);
    acc = 0;
    for (int c = 0; c < 20 && !rsp_valid_o; c++) begin
      if (psel_o && penable_o) begin acc++; pready = (acc == 4); end
      @(negedge pclk);
    end
    pready = 1'b0;
    n_chk++;
    if (acc !== 4) begin n_fail++; $display("FAIL timeout_edge_cycles: got %0d ACCESS cycles, expected 4", acc); end
    pop_exp(e, ok);
    n_chk++;
    if (!ok || rsp_rdata_o !== e.rdata || rsp_err_o !== e.err) begin
      n_fail++; $display("FAIL timeout_edge_rsp: rdata=%h err=%b, expected %h %b", rsp_rdata_o, rsp_err_o, e.rdata, e.err);
    end
    ack_rsp();
  endtask

  task automatic test_misaligned();
    exp_t e; bit ok;
    pready = 1'b1; prdata = 32'h1111_2222; pslverr = 1'b0;
    sb.push_back(mk(32'h0, 1'b1));
    issue(32'h0000_1002, 1'b0, 32'h0, 4'h0, 3'b000);
    pop_exp(e, ok);
    n_chk++;
    if (!ok || psel_o !== 0 || pwakeup_o !== 0 || rsp_valid_o !== 1 || rsp_rdata_o !== e.rdata || rsp_err_o !== e.err) begin
      n_fail++; $display("FAIL misaligned_rsp: psel=%b wk=%b rv=%b rdata=%h err=%b, expected 0 0 1 %h %b",
                         psel_o, pwakeup_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, e.rdata, e.err);
    end
    ack_rsp();
    pready = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit quiet;
    pready = 1'b0;
    issue(32'h0000_0040, 1'b1, 32'h9999_0000, 4'hF, 3'b000);
    @(negedge pclk);
    #2 prst_ni = 1'b0;
    #1;
    n_chk++;
    if (psel_o !== 0 || penable_o !== 0 || pwakeup_o !== 0 || rsp_valid_o !== 0) begin
      n_fail++; $display("FAIL reset_mid_async: psel=%b pen=%b wk=%b rv=%b, expected 0 0 0 0", psel_o, penable_o, pwakeup_o, rsp_valid_o);
    end
    @(negedge pclk);
    prst_ni = 1'b1;
    pready = 1'b1;
    quiet = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge pclk);
      if (rsp_valid_o !== 0 || psel_o !== 0 || req_ready_o !== 1) quiet = 1'b0;
    end
    pready = 1'b0;
    n_chk++;
    if (quiet !== 1'b1) begin n_fail++; $display("FAIL reset_mid_release: pending response not discarded, got %b expected 1", quiet); end
  endtask

  task automatic test_back_to_back();
    exp_t e; bit ok; int acc, waits, bad_acc, bad_rsp;
    logic we, slv;
    logic [31:0] rd, wd, a;
    bad_acc = 0; bad_rsp = 0;
    for (int i = 0; i < 8; i++) begin
      we = 1'($urandom); slv = 1'($urandom); rd = $urandom; wd = $urandom;
      a = $urandom & 32'hFFFF_FFFC;
      waits = $urandom_range(0, 2);
      prdata = rd; pslverr = slv; pready = 1'b0;
      sb.push_back(mk(we ? 32'h0 : rd, slv));
      issue(a, we, wd, 4'($urandom), 3'($urandom));
      acc = 0;
      for (int c = 0; c < 20 && !rsp_valid_o; c++) begin
        if (psel_o && penable_o) begin acc++; pready = (acc == waits + 1); end
        @(negedge pclk);
      end
      pready = 1'b0;
      if (acc != waits + 1) bad_acc++;
      pop_exp(e, ok);
      if (!ok || rsp_valid_o !== 1 || rsp_rdata_o !== e.rdata || rsp_err_o !== e.err) begin
        bad_rsp++;
        $display("FAIL b2b_rsp[%0d]: rdata=%h err=%b, expected %h %b", i, rsp_rdata_o, rsp_err_o, e.rdata, e.err);
      end
      ack_rsp();
    end
    n_chk++;
    if (bad_acc !== 0) begin n_fail++; $display("FAIL b2b_wait_states: %0d transfers with wrong ACCESS length, expected 0", bad_acc); end
    n_chk++;
    if (bad_rsp !== 0) begin n_fail++; $display("FAIL b2b_responses: %0d wrong responses, expected 0", bad_rsp); end
  endtask

  initial begin
    @(negedge pclk);
    test_reset();
    test_read();
    test_write_wait();
    test_slverr_hold();
    test_timeout();
    test_misaligned();
    test_reset_mid();
    test_back_to_back();
    n_chk++;
    if (sb.size() !== 0) begin n_fail++; $display("FAIL scoreboard_empty: %0d entries left, expected 0", sb.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
